// File: rtl/tinyalu_arbiter_if.sv
// tinyalu_arbiter_if: request, response and ALU pin bundle for the TinyALU arbiter
// Parameters: NUM_REQ requesters, ID_W bits of response id.
// Signals: req_valid/req_ready/req_a/req_b/req_op (per-requester, packed slices),
//          rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_err (shared response channel),
//          alu_a/alu_b/alu_op/alu_start/alu_done/alu_result (TinyALU pins).
// Modports: slave = arbiter side, master = requesters, response sink and ALU side.
interface tinyalu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2
);
    logic [NUM_REQ-1:0] req_valid, req_ready;
    logic [NUM_REQ*8-1:0] req_a, req_b;
    logic [NUM_REQ*3-1:0] req_op;
    logic rsp_valid, rsp_ready, rsp_err;
    logic [ID_W-1:0] rsp_id;
    logic [15:0] rsp_result;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic alu_start, alu_done;
    logic [15:0] alu_result;
    modport slave (
        input req_valid, req_a, req_b, req_op, rsp_ready, alu_done, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start
    );
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_done, alu_result,
        input req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start
    );
endinterface

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin sharing of one TinyALU between NUM_REQ requesters
// Ports: clk, reset_n (synchronous, active low), bus (tinyalu_arbiter_if.slave) carrying
//        the request handshakes, the tagged response channel and the ALU pins.
// Optional: define ALU_TIMEOUT_EN to abort an ALU wait after TIMEOUT_CYCLES with rsp_err=1.
module tinyalu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic clk,
    input logic reset_n,
    tinyalu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_d;
    logic [ID_W-1:0] rr_ptr, win, idx, id_q;
    logic [7:0] a_q, b_q, sel_a, sel_b;
    logic [2:0] op_q, sel_op;
    logic [15:0] result_q;
    logic found, grant, illegal, timeout, nop_q, err_q;

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == ID_W'(i)) begin
                sel_a = bus.req_a[8*i +: 8];
                sel_b = bus.req_b[8*i +: 8];
                sel_op = bus.req_op[3*i +: 3];
            end
    end

    assign grant = reset_n && state == IDLE && found;
    assign illegal = sel_op > 3'd4;

`ifdef ALU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;
    // Zero whenever not in ISSUE, so it is clear on every ISSUE entry.
    always_ff @(posedge clk) begin
        if (!reset_n || state != ISSUE)
            wd_cnt <= '0;
        else if (!nop_q)
            wd_cnt <= wd_cnt + 1'b1;
    end
    assign timeout = state == ISSUE && !nop_q && !bus.alu_done && wd_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (grant) state_d = illegal ? RESP : ISSUE;
            ISSUE: if (nop_q || bus.alu_done || timeout) state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            id_q <= '0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            nop_q <= 1'b0;
            result_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            if (grant) begin
                id_q <= win;
                rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                nop_q <= sel_op == 3'd0;
                result_q <= '0;
                err_q <= illegal;
                // Illegal ops never reach the ALU, so its pins keep their last values.
                if (!illegal) begin
                    a_q <= sel_a;
                    b_q <= sel_b;
                    op_q <= sel_op;
                end
            end
            if (state == ISSUE && !nop_q && bus.alu_done) begin
                result_q <= bus.alu_result;
                err_q <= 1'b0;
            end
            if (timeout)
                err_q <= 1'b1;
        end
    end

    assign bus.req_ready = grant ? NUM_REQ'(1) << win : '0;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_id = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err = err_q;
    assign bus.alu_a = a_q;
    assign bus.alu_b = b_q;
    assign bus.alu_op = op_q;
    assign bus.alu_start = state == ISSUE;
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed bench for tinyalu_arbiter with a transaction-level reference model
// Holds an ALU responder (add/and/xor answer after 1 cycle, mul after 3), a per-cycle
// round-robin/response model checker, and directed tests with literal expectations.
module tb_tinyalu_arbiter;
    localparam int N = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tinyalu_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();
    tinyalu_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit alu_en = 1'b1;
    bit stray_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd1: return 16'(a) + 16'(b);
            3'd2: return {8'h00, a & b};
            3'd3: return {8'h00, a ^ b};
            3'd4: return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // ALU responder: counts start cycles of a real op and pulses done once.
    initial begin
        int cnt;
        cnt = 0;
        bus.alu_done = 1'b0;
        bus.alu_result = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.alu_done) begin
                bus.alu_done = 1'b0;
                cnt = 0;
            end else if (bus.alu_start && alu_en && bus.alu_op >= 3'd1 && bus.alu_op <= 3'd4) begin
                cnt++;
                if (cnt == ((bus.alu_op == 3'd4) ? 3 : 1)) begin
                    bus.alu_done = 1'b1;
                    bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
                end
            end else begin
                cnt = 0;
                bus.alu_done = stray_done;
            end
        end
    end

    // Reference model: one transaction in flight, round-robin pointer, expected response.
    int m_ptr;
    bit outstanding, have_prev;
    logic [IW-1:0] e_id, p_id;
    logic [15:0] e_res, p_res;
    logic e_err, p_err;
    logic [7:0] c_a, c_b;
    logic [2:0] c_op;

    initial begin
        logic [N-1:0] eg;
        int w;
        m_ptr = 0;
        outstanding = 1'b0;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_ptr = 0;
                outstanding = 1'b0;
                have_prev = 1'b0;
            end else begin
                eg = '0;
                if (!outstanding)
                    for (int k = 0; k < N; k++)
                        if (eg == '0 && bus.req_valid[(m_ptr + k) % N]) eg[(m_ptr + k) % N] = 1'b1;
                check("req_ready", 32'(bus.req_ready), 32'(eg));
                if (!outstanding) begin
                    check("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
                    check("alu_start_idle", 32'(bus.alu_start), 32'd0);
                end else if (bus.alu_start) begin
                    check("alu_start_legal", 32'(c_op > 3'd4), 32'd0);
                    check("alu_a", 32'(bus.alu_a), 32'(c_a));
                    check("alu_b", 32'(bus.alu_b), 32'(c_b));
                    check("alu_op", 32'(bus.alu_op), 32'(c_op));
                end
                if (outstanding && bus.rsp_valid) begin
                    if (have_prev) begin
                        check("hold_id", 32'(bus.rsp_id), 32'(p_id));
                        check("hold_res", 32'(bus.rsp_result), 32'(p_res));
                        check("hold_err", 32'(bus.rsp_err), 32'(p_err));
                    end
                    if (bus.rsp_ready) begin
                        check("rsp_id", 32'(bus.rsp_id), 32'(e_id));
                        check("rsp_result", 32'(bus.rsp_result), 32'(e_res));
                        check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
                        outstanding = 1'b0;
                        have_prev = 1'b0;
                    end else begin
                        p_id = bus.rsp_id;
                        p_res = bus.rsp_result;
                        p_err = bus.rsp_err;
                        have_prev = 1'b1;
                    end
                end
                if (eg != '0 && bus.req_ready == eg) begin
                    w = 0;
                    for (int k = 0; k < N; k++)
                        if (eg[k]) w = k;
                    c_a = bus.req_a[8*w +: 8];
                    c_b = bus.req_b[8*w +: 8];
                    c_op = bus.req_op[3*w +: 3];
                    e_id = IW'(w);
                    e_err = c_op > 3'd4 || (c_op != 3'd0 && !alu_en);
                    e_res = (e_err || c_op == 3'd0) ? 16'h0 : alu_fn(c_a, c_b, c_op);
                    m_ptr = (w + 1) % N;
                    outstanding = 1'b1;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
        check({tag, "_alu_start"}, 32'(bus.alu_start), 32'd0);
    endtask

    task automatic wait_grant(input int i);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.req_ready[i] && t < 20);
        check("grant_seen", 32'(bus.req_ready[i]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input int hold, output logic [IW-1:0] id, output logic [15:0] res,
                       output logic err, output int lat, output int st);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
        bus.req_op[3*i +: 3] = op;
        bus.req_valid[i] = 1'b1;
        wait_grant(i);
        bus.req_valid[i] = 1'b0;
        lat = 0;
        st = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.alu_start) st++;
        end while (!bus.rsp_valid && lat < 100);
        check("rsp_arrives", 32'(bus.rsp_valid), 32'd1);
        id = bus.rsp_id;
        res = bus.rsp_result;
        err = bus.rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_id", 32'(bus.rsp_id), 32'(id));
            check("bp_res", 32'(bus.rsp_result), 32'(res));
            check("bp_err", 32'(bus.rsp_err), 32'(err));
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("rsp_released", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] id;
        logic [15:0] res;
        logic err;
        int lat, st, got, t;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        run(0, 8'h12, 8'h34, 3'd1, 0, id, res, err, lat, st);
        check("add_id", 32'(id), 32'd0);
        check("add_res", 32'(res), 32'h0046);
        check("add_err", 32'(err), 32'd0);
        check("add_lat", 32'(lat), 32'd2);
        check("add_starts", 32'(st), 32'd1);

        bus.rsp_ready = 1'b0;
        run(2, 8'hFF, 8'hFF, 3'd4, 5, id, res, err, lat, st);
        check("mul_id", 32'(id), 32'd2);
        check("mul_res", 32'(res), 32'hFE01);
        check("mul_err", 32'(err), 32'd0);
        check("mul_lat", 32'(lat), 32'd4);
        check("mul_starts", 32'(st), 32'd3);

        run(1, 8'h55, 8'h66, 3'd0, 0, id, res, err, lat, st);
        check("nop_id", 32'(id), 32'd1);
        check("nop_res", 32'(res), 32'd0);
        check("nop_err", 32'(err), 32'd0);
        check("nop_lat", 32'(lat), 32'd2);
        check("nop_starts", 32'(st), 32'd1);

        run(3, 8'h77, 8'h88, 3'd6, 0, id, res, err, lat, st);
        check("ill_id", 32'(id), 32'd3);
        check("ill_res", 32'(res), 32'd0);
        check("ill_err", 32'(err), 32'd1);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_starts", 32'(st), 32'd0);

        stray_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stray_done = 1'b0;
        @(posedge clk);
        #1;
        check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        run(1, 8'hC3, 8'hA5, 3'd2, 0, id, res, err, lat, st);
        check("and_id", 32'(id), 32'd1);
        check("and_res", 32'(res), 32'h0081);

        bus.req_a[23:16] = 8'h10;
        bus.req_b[23:16] = 8'h10;
        bus.req_op[8:6] = 3'd4;
        bus.req_valid[2] = 1'b1;
        wait_grant(2);
        bus.req_valid[2] = 1'b0;
        check("midop_start", 32'(bus.alu_start), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("midreset");
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("aborted_no_rsp", 32'(bus.rsp_valid), 32'd0);

        for (int i = 0; i < N; i++) begin
            bus.req_a[8*i +: 8] = 8'hF0;
            bus.req_b[8*i +: 8] = 8'h0F;
            bus.req_op[3*i +: 3] = 3'd3;
        end
        bus.req_valid = '1;
        got = 0;
        t = 0;
        while (got < 8 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rr_id", 32'(bus.rsp_id), 32'(got % N));
                check("rr_res", 32'(bus.rsp_result), 32'h00FF);
                got++;
            end
        end
        check("rr_count", 32'(got), 32'd8);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

`ifdef ALU_TIMEOUT_EN
        alu_en = 1'b0;
        run(0, 8'h01, 8'h02, 3'd1, 0, id, res, err, lat, st);
        check("to_id", 32'(id), 32'd0);
        check("to_res", 32'(res), 32'd0);
        check("to_err", 32'(err), 32'd1);
        check("to_lat", 32'(lat), 32'd17);
        check("to_starts", 32'(st), 32'd16);
        check("to_start_low", 32'(bus.alu_start), 32'd0);
        alu_en = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
